soc_system_pio_in_filt_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO: next generation of the edge-capture input port.

---
 rtl/soc_system_pio_in_pkg.sv | 18 +
 rtl/soc_system_pio_in_chan.sv | 74 +++++++
 rtl/soc_system_pio_in_filt_irq.sv | 115 +++++++++++
 tb/tb_soc_system_pio_in_filt_irq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_in_pkg.sv
// Shared register-map constants and bus helpers for the filtered input PIO.
package soc_system_pio_in_pkg;

    localparam logic [2:0] ADDR_DATA  = 3'd0;  // filtered input value, read-only
    localparam logic [2:0] ADDR_RSVD1 = 3'd1;  // reads 0, writes ignored
    localparam logic [2:0] ADDR_MASK  = 3'd2;  // irq mask
    localparam logic [2:0] ADDR_EDGE  = 3'd3;  // edge capture, write-1-to-clear
    localparam logic [2:0] ADDR_RISE  = 3'd4;  // rising-edge enable
    localparam logic [2:0] ADDR_FALL  = 3'd5;  // falling-edge enable
    localparam logic [2:0] ADDR_FILT  = 3'd6;  // glitch filter length
    localparam logic [2:0] ADDR_RSVD7 = 3'd7;  // reads 0, writes ignored

    // Avalon write strobe: slave selected and active-low write asserted.
    function automatic logic pio_wr_en(input logic cs, input logic wr_n);
        return cs & ~wr_n;
    endfunction

endpackage

// File: rtl/soc_system_pio_in_chan.sv
// One input channel: synchroniser, glitch filter, edge classification and
// the sticky edge-capture bit.
module soc_system_pio_in_chan #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_bit,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              rise_en,
    input  logic              fall_en,
    input  logic              clr,
    output logic              filt,
    output logic              cap
);

    localparam logic [FILT_W-1:0] ONE = FILT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   cap_q, cap_d;
    logic                   s_s;
    logic                   evt_s;
    logic                   set_s;

    // Next-state for synchroniser, filter counter, filtered value and capture bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
        s_s    = sync_q[SYNC_STAGES-1];
        cnt_d  = cnt_q;
        filt_d = filt_q;
        evt_s  = 1'b0;
        if (s_s == filt_q) begin
            cnt_d = '0;
        end else if ((filt_len <= ONE) || (cnt_q >= (filt_len - ONE))) begin
            // Input has disagreed long enough: accept it as the new level.
            filt_d = s_s;
            cnt_d  = '0;
            evt_s  = 1'b1;
        end else begin
            cnt_d = cnt_q + ONE;
        end
        set_s = evt_s & ((s_s & rise_en) | (~s_s & fall_en));
        // A new event wins over a simultaneous software clear so no edge is lost.
        if (set_s) begin
            cap_d = 1'b1;
        end else if (clr) begin
            cap_d = 1'b0;
        end else begin
            cap_d = cap_q;
        end
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
            cap_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            cap_q  <= cap_d;
        end
    end

    assign filt = filt_q;
    assign cap  = cap_q;

endmodule

// File: rtl/soc_system_pio_in_filt_irq.sv
// Avalon-MM input PIO with synchronised, glitch-filtered channels, per-bit
// rise/fall edge capture and a masked, registered level interrupt.
module soc_system_pio_in_filt_irq
    import soc_system_pio_in_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      FILT_W      = 8,
    parameter logic [WIDTH-1:0] RISE_RST    = '1,
    parameter logic [WIDTH-1:0] FALL_RST    = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic              write_s;
    logic [WIDTH-1:0]  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [FILT_W-1:0] filt_len_q, filt_len_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d;
    logic [WIDTH-1:0]  filt_s;
    logic [WIDTH-1:0]  cap_s;
    logic [WIDTH-1:0]  clr_s;

    // Write-data bits above the channel count are intentionally discarded.
    logic unused_wdata_s;
    assign unused_wdata_s = ^writedata;

    // Per-channel datapath, one instance per input bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        soc_system_pio_in_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .in_bit   (in_port[i]),
            .filt_len (filt_len_q),
            .rise_en  (rise_en_q[i]),
            .fall_en  (fall_en_q[i]),
            .clr      (clr_s[i]),
            .filt     (filt_s[i]),
            .cap      (cap_s[i])
        );
    end

    // CSR write decode and W1C clear vector for the capture bits.
    always_comb begin
        write_s    = pio_wr_en(chipselect, write_n);
        irqmask_d  = irqmask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        filt_len_d = filt_len_q;
        clr_s      = '0;
        if (write_s) begin
            case (address)
                ADDR_MASK: irqmask_d  = writedata[WIDTH-1:0];
                ADDR_EDGE: clr_s      = writedata[WIDTH-1:0];
                ADDR_RISE: rise_en_d  = writedata[WIDTH-1:0];
                ADDR_FALL: fall_en_d  = writedata[WIDTH-1:0];
                ADDR_FILT: filt_len_d = writedata[FILT_W-1:0];
                default:   clr_s      = '0;
            endcase
        end else begin
            clr_s = '0;
        end
    end

    // Read mux (zero-extended to the bus width) and interrupt level.
    always_comb begin
        readdata_d = 32'h0000_0000;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0]  = filt_s;
            ADDR_MASK: readdata_d[WIDTH-1:0]  = irqmask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0]  = cap_s;
            ADDR_RISE: readdata_d[WIDTH-1:0]  = rise_en_q;
            ADDR_FALL: readdata_d[WIDTH-1:0]  = fall_en_q;
            ADDR_FILT: readdata_d[FILT_W-1:0] = filt_len_q;
            default:   readdata_d             = 32'h0000_0000;
        endcase
        irq_d = |(cap_s & irqmask_q);
    end

    // Control registers, read-data register and interrupt register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q  <= '0;
            rise_en_q  <= RISE_RST;
            fall_en_q  <= FALL_RST;
            filt_len_q <= '0;
            readdata_q <= 32'h0000_0000;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            filt_len_q <= filt_len_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_in_filt_irq.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a behavioural model; a 32-bit and an 8-bit build share one bus.
module tb_soc_system_pio_in_filt_irq;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] in_port;
    logic        irq;
    logic [31:0] readdata8;
    logic        irq8;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [31:0] m_pipe [SYNC];
    logic [31:0] m_filt, m_cap, m_mask, m_rise, m_fall, m_rd, m_rd8;
    logic [7:0]  m_len;
    logic        m_irq, m_irq8;
    int          m_run [32];

    always #5 clk = ~clk;

    soc_system_pio_in_filt_irq #(.WIDTH(32), .SYNC_STAGES(SYNC), .FILT_W(8)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    soc_system_pio_in_filt_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .FILT_W(8)) dut8 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata8),
        .in_port(in_port[7:0]), .irq(irq8)
    );

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_pipe[k] = 32'h0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
        m_filt = 32'h0; m_cap = 32'h0; m_mask = 32'h0;
        m_rise = 32'hFFFF_FFFF; m_fall = 32'hFFFF_FFFF; m_len = 8'h00;
        m_rd = 32'h0; m_rd8 = 32'h0; m_irq = 1'b0; m_irq8 = 1'b0;
    endtask

    // Advance model and DUT by one clock, then compare all outputs.
    task automatic step();
        logic [31:0] s, evt, setv, clr, rd;
        bit wr;
        int lim;
        s  = m_pipe[SYNC-1];
        wr = (chipselect === 1'b1) && (write_n === 1'b0);
        case (address)
            3'd0:    rd = m_filt;
            3'd2:    rd = m_mask;
            3'd3:    rd = m_cap;
            3'd4:    rd = m_rise;
            3'd5:    rd = m_fall;
            3'd6:    rd = {24'h0, m_len};
            default: rd = 32'h0;
        endcase
        m_rd   = rd;
        m_rd8  = (address == 3'd6) ? rd : (rd & 32'h0000_00FF);
        m_irq  = |(m_cap & m_mask);
        m_irq8 = |(m_cap & m_mask & 32'h0000_00FF);
        lim = (m_len > 8'd1) ? int'(m_len) : 1;
        evt = 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (s[i] !== m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] >= lim) begin
                    evt[i]   = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        setv   = evt & ((s & m_rise) | (~s & m_fall));
        clr    = (wr && address == 3'd3) ? writedata : 32'h0;
        m_filt = (m_filt & ~evt) | (s & evt);
        m_cap  = setv | (m_cap & ~clr);
        if (wr) begin
            case (address)
                3'd2:    m_mask = writedata;
                3'd4:    m_rise = writedata;
                3'd5:    m_fall = writedata;
                3'd6:    m_len  = writedata[7:0];
                default: m_len  = m_len;
            endcase
        end
        for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = in_port;
        @(posedge clk);
        #1;
        expect_val("model_rd32", readdata, m_rd);
        expect_val("model_irq32", {31'h0, irq}, {31'h0, m_irq});
        expect_val("model_rd8", readdata8, m_rd8);
        expect_val("model_irq8", {31'h0, irq8}, {31'h0, m_irq8});
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0; write_n = 1'b1;
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        chipselect = 1'b0;
        expect_val(tag, readdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        int r;
        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_val("por_readdata", readdata, 32'h0);
        expect_val("por_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        rd(3'd4, 32'hFFFF_FFFF, "rst_rise_en");
        rd(3'd5, 32'hFFFF_FFFF, "rst_fall_en");
        rd(3'd6, 32'h0, "rst_filt_len");
        rd(3'd3, 32'h0, "rst_edgecap");

        // any-edge capture and W1C
        in_port = 32'h0000_0005;
        idle(SYNC + 2);
        rd(3'd3, 32'h5, "anyedge_cap");
        rd(3'd0, 32'h5, "anyedge_data");
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h4, "w1c_bit0");
        in_port = 32'h0;
        idle(SYNC + 2);
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, 32'h0, "w1c_all");

        // falling edges disabled
        wr(3'd5, 32'h0);
        in_port = 32'h1;
        idle(SYNC + 2);
        wr(3'd3, 32'hFFFF_FFFF);
        in_port = 32'h0;
        idle(SYNC + 2);
        rd(3'd3, 32'h0, "fall_disabled");
        in_port = 32'h1;
        idle(SYNC + 2);
        rd(3'd3, 32'h1, "rise_captured");
        wr(3'd5, 32'hFFFF_FFFF);
        in_port = 32'h0;
        idle(SYNC + 2);
        wr(3'd3, 32'hFFFF_FFFF);

        // glitch filter of length 4
        wr(3'd6, 32'h4);
        in_port = 32'h4;
        idle(3);
        in_port = 32'h0;
        idle(SYNC + 6);
        rd(3'd0, 32'h0, "glitch_data");
        rd(3'd3, 32'h0, "glitch_cap");
        in_port = 32'h4;
        idle(SYNC + 6);
        rd(3'd0, 32'h4, "filt_pass_data");
        rd(3'd3, 32'h4, "filt_pass_cap");
        in_port = 32'h0;
        idle(SYNC + 6);
        wr(3'd6, 32'h0);
        wr(3'd3, 32'hFFFF_FFFF);

        // masked interrupt timing
        wr(3'd2, 32'h8);
        in_port = 32'h8;
        idle(SYNC + 1);
        expect_val("irq_not_yet", {31'h0, irq}, 32'h0);
        idle(1);
        expect_val("irq_asserted", {31'h0, irq}, 32'h1);
        in_port = 32'h0;
        idle(SYNC + 2);
        wr(3'd3, 32'hFFFF_FFFF);
        idle(1);
        expect_val("irq_cleared", {31'h0, irq}, 32'h0);
        in_port = 32'h2;
        idle(SYNC + 3);
        expect_val("irq_unmasked_bit", {31'h0, irq}, 32'h0);
        rd(3'd3, 32'h2, "cap_bit1");

        // set/clear race on bit0
        wr(3'd2, 32'h1);
        in_port = 32'h3;
        idle(SYNC + 2);
        rd(3'd3, 32'h3, "race_pre");
        in_port = 32'h2;
        idle(SYNC);
        wr(3'd3, 32'h1);
        expect_val("race_irq_edge", {31'h0, irq}, 32'h1);
        rd(3'd3, 32'h3, "race_cap");
        expect_val("race_irq", {31'h0, irq}, 32'h1);
        wr(3'd2, 32'h0);
        wr(3'd3, 32'hFFFF_FFFF);

        // narrow build ignores upper bits
        wr(3'd2, 32'hFFFF_FF00);
        expect_val("w8_mask_upper", readdata8, 32'h0);
        rd(3'd2, 32'hFFFF_FF00, "w32_mask");
        wr(3'd2, 32'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                in_port = $urandom;
            end else if (r < 4) begin
                in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
            end else begin
                in_port = in_port;
            end
            r = $urandom_range(0, 9);
            if (r < 2) begin
                address = 3'($urandom_range(0, 7));
                chipselect = 1'b1; write_n = 1'b0;
                writedata = (address == 3'd6) ? 32'($urandom_range(0, 5)) : $urandom;
            end else if (r < 7) begin
                address = 3'($urandom_range(0, 7));
                chipselect = 1'b1; write_n = 1'b1; writedata = $urandom;
            end else begin
                chipselect = 1'b0; write_n = 1'b1;
            end
            step();
        end
        chipselect = 1'b0; write_n = 1'b1;

        // asynchronous reset in the middle of traffic
        in_port = $urandom;
        #2;
        reset = 1'b1;
        #1;
        expect_val("midrst_readdata", readdata, 32'h0);
        expect_val("midrst_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        in_port = 32'h0;
        reset = 1'b0;
        rd(3'd4, 32'hFFFF_FFFF, "midrst_rise_en");
        rd(3'd5, 32'hFFFF_FFFF, "midrst_fall_en");
        rd(3'd6, 32'h0, "midrst_filt_len");
        rd(3'd3, 32'h0, "midrst_edgecap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
